// File: rtl/clock_phase_generator.sv
// -----------------------------------------------------------------------------
// clock_phase_generator
//
// Produces the three-phase timing references (P/Q/R and complements) and the
// BOP clock-driver enable. The master oscillator is divided into an 8-step
// bit-time sequence. The block runs a power-up warm-up, asserts BOP and then
// shuts down in order when power fails. It also numbers bit times for the
// rest of the machine.
//
// Parameters
//   DIV     CLK cycles per step (>= 2)
//   WARMUP  full 8-step cycles run with BOP low before BOP asserts (>= 1)
//   BT_MAX  last bit-time number; BT wraps BT_MAX -> 0
//
// Ports
//   CLK        in   master oscillator; all state changes on the rising edge
//   RESETN     in   asynchronous active-low reset
//   PWR_OK     in   power-good level, synchronous to CLK
//   SS_MODE    in   single-step maintenance mode
//   SS_STEP    in   single-step request level; each rising edge advances one step
//   CGPP/CGPPN out  P phase reference and complement (registered)
//   CGQP/CGQPN out  Q phase reference and complement (registered)
//   CGRP/CGRPN out  R phase reference and complement (registered)
//   BOP        out  clock-driver enable (registered)
//   STEP       out  current step 0..7
//   BT         out  current bit time 0..BT_MAX
//   BT_END     out  high during the final CLK of step 7 in RUN/DRAIN
//   RUNNING    out  high in WARMUP, RUN and DRAIN
//   DBG_STATE  out  FSM state: 0 OFF, 1 WARMUP, 2 RUN, 3 DRAIN
//
// There is no valid/ready handshake here. SS_STEP is a level, and only its
// rising edge matters. PWR_OK and SS_MODE are levels sampled on every edge.
// -----------------------------------------------------------------------------
module clock_phase_generator #(
   parameter int DIV    = 4,
   parameter int WARMUP = 2,
   parameter int BT_MAX = 13
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       PWR_OK,
   input  logic       SS_MODE,
   input  logic       SS_STEP,
   output logic       CGPP,
   output logic       CGPPN,
   output logic       CGQP,
   output logic       CGQPN,
   output logic       CGRP,
   output logic       CGRPN,
   output logic       BOP,
   output logic [2:0] STEP,
   output logic [3:0] BT,
   output logic       BT_END,
   output logic       RUNNING,
   output logic [1:0] DBG_STATE
);

   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

   typedef enum logic [1:0] {
      S_OFF    = 2'd0,
      S_WARMUP = 2'd1,
      S_RUN    = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   state_t        state, state_nx;
   logic [DW-1:0] dcnt, dcnt_nx;
   logic [WW-1:0] wcnt, wcnt_nx;
   logic [2:0]    step_nx;
   logic [3:0]    bt_nx;
   logic          ss_mode_q, ss_step_q, ss_edge_q;
   logic          tick, last_step;
   logic          p_nx, q_nx, r_nx, bop_nx;

   // The mode is taken from its register, so a change of SS_MODE acts on the
   // next CLK. The single-step edge is registered too. This keeps BT_END free
   // of any combinational path from the inputs.
   assign tick      = (state != S_OFF) &&
                      (ss_mode_q ? ss_edge_q : (dcnt == DW'(DIV - 1)));
   assign last_step = (STEP == 3'd7);

   // ---------------------------------------------------------------------------
   // State register (all sequential state)
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state     <= S_OFF;
         dcnt      <= '0;
         wcnt      <= '0;
         STEP      <= '0;
         BT        <= '0;
         ss_mode_q <= 1'b0;
         ss_step_q <= 1'b0;
         ss_edge_q <= 1'b0;
         CGPP      <= 1'b0;
         CGPPN     <= 1'b1;
         CGQP      <= 1'b0;
         CGQPN     <= 1'b1;
         CGRP      <= 1'b0;
         CGRPN     <= 1'b1;
         BOP       <= 1'b0;
      end else begin
         state     <= state_nx;
         dcnt      <= dcnt_nx;
         wcnt      <= wcnt_nx;
         STEP      <= step_nx;
         BT        <= bt_nx;
         ss_mode_q <= SS_MODE;
         ss_step_q <= SS_STEP;
         ss_edge_q <= SS_STEP & ~ss_step_q;
         CGPP      <= p_nx;
         CGPPN     <= ~p_nx;
         CGQP      <= q_nx;
         CGQPN     <= ~q_nx;
         CGRP      <= r_nx;
         CGRPN     <= ~r_nx;
         BOP       <= bop_nx;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      wcnt_nx  = wcnt;
      step_nx  = STEP;
      bt_nx    = BT;
      unique case (state)
         S_OFF: begin
            step_nx = 3'd0;
            wcnt_nx = '0;
            if (PWR_OK) state_nx = S_WARMUP;
         end
         S_WARMUP: begin
            if (!PWR_OK) begin
               state_nx = S_OFF;
               step_nx  = 3'd0;
               wcnt_nx  = '0;
            end else if (tick) begin
               step_nx = STEP + 3'd1;
               if (last_step) begin
                  if (wcnt == WW'(WARMUP - 1)) begin
                     state_nx = S_RUN;
                     wcnt_nx  = '0;
                     bt_nx    = 4'd0;
                  end else begin
                     wcnt_nx = wcnt + WW'(1);
                  end
               end
            end
         end
         S_RUN: begin
            if (tick) begin
               step_nx = STEP + 3'd1;
               if (last_step) bt_nx = (BT == 4'(BT_MAX)) ? 4'd0 : BT + 4'd1;
            end
            if (!PWR_OK) state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            // Once draining, the shutdown finishes at the end of the bit time,
            // even if power comes back.
            if (tick) begin
               step_nx = STEP + 3'd1;
               if (last_step) state_nx = S_OFF;
            end
         end
         default: state_nx = S_OFF;
      endcase

      // The divider is held at 0 while single-stepping. It restarts from 0 on
      // a change of mode in either direction, and it is idle outside the
      // running states.
      if (state == S_OFF || state_nx == S_OFF || SS_MODE || ss_mode_q || tick)
         dcnt_nx = '0;
      else
         dcnt_nx = dcnt + DW'(1);
   end

   // ---------------------------------------------------------------------------
   // Output logic: phase/BOP next values (registered above) and the
   // state-decoded outputs.
   // ---------------------------------------------------------------------------
   always_comb begin
      p_nx   = 1'b0;
      q_nx   = 1'b0;
      r_nx   = 1'b0;
      bop_nx = 1'b0;
      if (state_nx != S_OFF) begin
         case (step_nx)
            3'd0: begin p_nx = 1'b1; q_nx = 1'b1; end
            3'd1: begin p_nx = 1'b1; q_nx = 1'b1; r_nx = 1'b1; end
            3'd2: begin p_nx = 1'b1; r_nx = 1'b1; end
            3'd3: begin p_nx = 1'b1; end
            3'd4: begin q_nx = 1'b1; end
            3'd5: begin q_nx = 1'b1; r_nx = 1'b1; end
            3'd6: begin r_nx = 1'b1; end
            default: ;
         endcase
         bop_nx = (state_nx == S_RUN) || (state_nx == S_DRAIN);
      end
   end

   assign BT_END    = tick && last_step && ((state == S_RUN) || (state == S_DRAIN));
   assign RUNNING   = (state != S_OFF);
   assign DBG_STATE = state;

endmodule

// File: tb/tb_clock_phase_generator.sv
// -----------------------------------------------------------------------------
// tb_clock_phase_generator
//
// Self-checking bench for clock_phase_generator. A behavioural model tracks
// the total number of steps advanced, the bit times completed and the power
// state. Expected outputs are derived from these values with plain arithmetic.
// Each scenario task drives stimulus and compares inline.
// -----------------------------------------------------------------------------
module tb_clock_phase_generator;

   localparam int DIV     = 4;
   localparam int WARMUP  = 2;
   localparam int BT_MAX  = 13;
   localparam int BIT_CYC = 8 * DIV;
   localparam int M_OFF = 0, M_WARM = 1, M_RUN = 2, M_DRAIN = 3;
   localparam logic [15:0] RESET_VEC = {7'b0101010, 9'd0};

   logic       CLK = 1'b0;
   logic       RESETN, PWR_OK, SS_MODE, SS_STEP;
   logic       CGPP, CGPPN, CGQP, CGQPN, CGRP, CGRPN, BOP, BT_END, RUNNING;
   logic [2:0] STEP;
   logic [3:0] BT;
   logic [1:0] DBG_STATE;
   logic [15:0] obs;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   int m_state, m_steps, m_cyc, m_bits;
   bit m_ss_prev, m_ss_prev2, m_mode_prev;

   logic [3:0] exp_q[$];

   clock_phase_generator #(.DIV(DIV), .WARMUP(WARMUP), .BT_MAX(BT_MAX)) dut (
      .CLK(CLK), .RESETN(RESETN), .PWR_OK(PWR_OK), .SS_MODE(SS_MODE), .SS_STEP(SS_STEP),
      .CGPP(CGPP), .CGPPN(CGPPN), .CGQP(CGQP), .CGQPN(CGQPN), .CGRP(CGRP), .CGRPN(CGRPN),
      .BOP(BOP), .STEP(STEP), .BT(BT), .BT_END(BT_END), .RUNNING(RUNNING),
      .DBG_STATE(DBG_STATE)
   );

   assign obs = {CGPP, CGPPN, CGQP, CGQPN, CGRP, CGRPN, BOP, STEP, BT, BT_END, RUNNING};

   // ---------------------------------------------------------------- clock
   always #5 CLK = ~CLK;

   // ---------------------------------------------------------------- model
   task automatic model_reset();
      m_state = M_OFF; m_steps = 0; m_cyc = 0; m_bits = 0;
      m_ss_prev = 0; m_ss_prev2 = 0; m_mode_prev = 0;
   endtask

   // Whether the coming edge advances a step.
   function automatic bit model_tick();
      if (m_state == M_OFF) return 1'b0;
      if (m_mode_prev) return m_ss_prev && !m_ss_prev2;
      return m_cyc == DIV - 1;
   endfunction

   task automatic model_edge();
      bit t;
      int s, old;
      t = model_tick();
      s = m_steps % 8;
      old = m_state;
      case (m_state)
         M_OFF:   if (PWR_OK) begin m_state = M_WARM; m_steps = 0; end
         M_WARM:  if (!PWR_OK) begin m_state = M_OFF; m_steps = 0; end
                  else if (t) begin
                     m_steps++;
                     if (m_steps == WARMUP * 8) begin m_state = M_RUN; m_steps = 0; m_bits = 0; end
                  end
         M_RUN:   begin
                     if (t) begin m_steps++; if (s == 7) m_bits++; end
                     if (!PWR_OK) m_state = M_DRAIN;
                  end
         default: if (t) begin
                     m_steps++;
                     if (s == 7) begin m_state = M_OFF; m_steps = 0; end
                  end
      endcase
      if (old == M_OFF || m_state == M_OFF || SS_MODE || m_mode_prev || t) m_cyc = 0;
      else m_cyc++;
      m_ss_prev2  = m_ss_prev;
      m_ss_prev   = SS_STEP;
      m_mode_prev = SS_MODE;
   endtask

   function automatic logic [15:0] exp_vec();
      int s;
      bit on, p, q, r, bop, be;
      s   = m_steps % 8;
      on  = (m_state != M_OFF);
      p   = on && (s < 4);
      q   = on && ((s % 4) < 2);
      r   = on && (s inside {1, 2, 5, 6});
      bop = (m_state == M_RUN) || (m_state == M_DRAIN);
      be  = model_tick() && (s == 7) && bop;
      return {p, !p, q, !q, r, !r, bop, 3'(s), 4'(m_bits % (BT_MAX + 1)), be, on};
   endfunction

   // ---------------------------------------------------------------- drivers
   // One rising edge; the model sees the same input values the DUT sampled.
   task automatic cyc();
      @(posedge CLK);
      if (!RESETN) model_reset();
      else model_edge();
      #1;
   endtask

   task automatic do_reset();
      RESETN = 1'b0; PWR_OK = 1'b0; SS_MODE = 1'b0; SS_STEP = 1'b0;
      model_reset();
      repeat (2) cyc();
      RESETN = 1'b1;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      do_reset();
      n_checks++;
      if (obs !== RESET_VEC) $display("FAIL reset_outputs: got %h want %h", obs, RESET_VEC); else n_pass++;
      n_checks++;
      if (DBG_STATE !== 2'd0) $display("FAIL reset_state: got %0d want 0", DBG_STATE); else n_pass++;
      repeat (3) begin
         cyc();
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL off_idle: got %h want %h", obs, exp_vec()); else n_pass++;
      end
   endtask

   task automatic test_warmup();
      int n, run_len;
      logic [2:0] prev;
      PWR_OK = 1'b1;
      cyc();
      n_checks++;
      if (obs !== {7'b1010010, 3'd0, 4'd0, 1'b0, 1'b1})
         $display("FAIL warmup_entry: got %h want %h", obs, {7'b1010010, 3'd0, 4'd0, 1'b0, 1'b1});
      else n_pass++;
      n = 0; run_len = 1; prev = STEP;
      while (BOP !== 1'b1 && n < 400) begin
         cyc(); n++;
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL warmup_cycle: got %h want %h", obs, exp_vec()); else n_pass++;
         n_checks++;
         if ({CGPP, CGQP, CGRP} !== ~{CGPPN, CGQPN, CGRPN})
            $display("FAIL complement: got %b want inverse of %b", {CGPPN, CGQPN, CGRPN}, {CGPP, CGQP, CGRP});
         else n_pass++;
         if (STEP === prev) run_len++;
         else begin
            n_checks++;
            if (run_len != DIV) $display("FAIL step_length: got %0d want %0d", run_len, DIV); else n_pass++;
            run_len = 1; prev = STEP;
         end
      end
      n_checks++;
      if (n != WARMUP * 8 * DIV) $display("FAIL bop_latency: got %0d want %0d", n, WARMUP * 8 * DIV); else n_pass++;
      n_checks++;
      if ({STEP, BT} !== 7'd0) $display("FAIL bop_step_bt: got %h want 0", {STEP, BT}); else n_pass++;
   endtask

   task automatic test_run_bt();
      int last;
      logic [3:0] e;
      for (int k = 0; k < 15; k++) exp_q.push_back(4'(k % (BT_MAX + 1)));
      last = -1;
      for (int c = 0; c < 15 * BIT_CYC; c++) begin
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL run_cycle: got %h want %h", obs, exp_vec()); else n_pass++;
         if (BT_END === 1'b1) begin
            n_checks++;
            if (STEP !== 3'd7) $display("FAIL bt_end_step: got %0d want 7", STEP); else n_pass++;
            n_checks++;
            if (last < 0 && c != BIT_CYC - 1) $display("FAIL bt_end_first: got %0d want %0d", c, BIT_CYC - 1);
            else if (last >= 0 && c - last != BIT_CYC) $display("FAIL bt_end_spacing: got %0d want %0d", c - last, BIT_CYC);
            else n_pass++;
            last = c;
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL bt_end_extra: got pulse at %0d want none", c);
            else begin
               e = exp_q.pop_front();
               if (BT !== e) $display("FAIL bt_sequence: got %0d want %0d", BT, e); else n_pass++;
            end
         end
         cyc();
      end
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL bt_end_count: got %0d missing want 0", exp_q.size()); else n_pass++;
      exp_q.delete();
   endtask

   task automatic test_drain();
      int n, d;
      n = 0;
      while (STEP !== 3'd2 && n < 2 * BIT_CYC) begin cyc(); n++; end
      n_checks++;
      if (STEP !== 3'd2) $display("FAIL drain_reach_step2: got %0d want 2", STEP); else n_pass++;
      repeat ($urandom_range(0, DIV - 1)) cyc();
      PWR_OK = 1'b0;
      d = 0;
      while (BOP === 1'b1 && d < BIT_CYC + 4) begin
         cyc(); d++;
         if (d == 3) PWR_OK = 1'b1;
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL drain_cycle: got %h want %h", obs, exp_vec()); else n_pass++;
         n_checks++;
         if (DBG_STATE !== 2'(m_state)) $display("FAIL drain_state: got %0d want %0d", DBG_STATE, m_state); else n_pass++;
      end
      n_checks++;
      if (d > BIT_CYC + 1) $display("FAIL drain_latency: got %0d want <= %0d", d, BIT_CYC + 1); else n_pass++;
      n_checks++;
      if ({obs[15:9], STEP, RUNNING, DBG_STATE} !== {7'b0101010, 3'd0, 1'b0, 2'd0})
         $display("FAIL drain_off: got %h want %h", {obs[15:9], STEP, RUNNING, DBG_STATE}, {7'b0101010, 3'd0, 1'b0, 2'd0});
      else n_pass++;
      cyc();
      n_checks++;
      if (obs !== exp_vec() || DBG_STATE !== 2'd1)
         $display("FAIL rewarm_entry: got %h/%0d want %h/1", obs, DBG_STATE, exp_vec());
      else n_pass++;
      n = 0;
      while (BOP !== 1'b1 && n < 400) begin cyc(); n++; end
      n_checks++;
      if (n != WARMUP * 8 * DIV) $display("FAIL rewarm_latency: got %0d want %0d", n, WARMUP * 8 * DIV); else n_pass++;
      n_checks++;
      if (BT !== 4'd0) $display("FAIL rewarm_bt: got %0d want 0", BT); else n_pass++;
   endtask

   task automatic test_warmup_abort();
      int k;
      do_reset();
      PWR_OK = 1'b1;
      cyc();
      k = $urandom_range(1, WARMUP * 8 * DIV - 2);
      repeat (k) begin
         cyc();
         n_checks++;
         if (obs !== exp_vec() || BOP !== 1'b0) $display("FAIL abort_warm: got %h want %h", obs, exp_vec()); else n_pass++;
      end
      PWR_OK = 1'b0;
      cyc();
      n_checks++;
      if (obs !== RESET_VEC || DBG_STATE !== 2'd0) $display("FAIL abort_off: got %h/%0d want %h/0", obs, DBG_STATE, RESET_VEC); else n_pass++;
      repeat (WARMUP * 8 * DIV) begin
         cyc();
         n_checks++;
         if (BOP !== 1'b0 || RUNNING !== 1'b0) $display("FAIL abort_stays_off: got %b%b want 00", BOP, RUNNING); else n_pass++;
      end
   endtask

   task automatic test_single_step();
      int n, changes, hold_changes, pulses, exp_pulses;
      logic [2:0] s0, prev;
      bit sched[$];
      do_reset();
      PWR_OK = 1'b1;
      cyc();
      n = 0;
      while (BOP !== 1'b1 && n < 400) begin cyc(); n++; end
      repeat ($urandom_range(0, 3 * BIT_CYC)) cyc();
      SS_MODE = 1'b1;
      repeat (3) cyc();
      s0 = STEP;
      repeat (6) begin
         cyc();
         n_checks++;
         if (STEP !== s0 || obs !== exp_vec()) $display("FAIL ss_idle: got %h want step %0d / %h", obs, s0, exp_vec()); else n_pass++;
      end
      for (int i = 0; i < 5; i++) sched.push_back(1'b1);
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(1, 3)) sched.push_back(1'b0);
         repeat ($urandom_range(1, 3)) sched.push_back(1'b1);
      end
      sched.push_back(1'b0); sched.push_back(1'b0);
      changes = 0; hold_changes = 0; pulses = 0; prev = STEP;
      for (int i = 0; i < sched.size(); i++) begin
         SS_STEP = sched[i];
         cyc();
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL ss_cycle: got %h want %h", obs, exp_vec()); else n_pass++;
         if (STEP !== prev) begin
            changes++;
            if (i < 5) hold_changes++;
            prev = STEP;
         end
         if (BT_END === 1'b1) pulses++;
      end
      exp_pulses = 0;
      for (int k = 0; k < 9; k++) if ((int'(s0) + k) % 8 == 7) exp_pulses++;
      n_checks++;
      if (hold_changes != 1) $display("FAIL ss_hold: got %0d steps want 1", hold_changes); else n_pass++;
      n_checks++;
      if (changes != 9) $display("FAIL ss_step_count: got %0d want 9", changes); else n_pass++;
      n_checks++;
      if (STEP !== 3'((int'(s0) + 9) % 8)) $display("FAIL ss_final_step: got %0d want %0d", STEP, (int'(s0) + 9) % 8); else n_pass++;
      n_checks++;
      if (pulses != exp_pulses) $display("FAIL ss_bt_end: got %0d want %0d", pulses, exp_pulses); else n_pass++;
      SS_MODE = 1'b0;
      repeat (2 * BIT_CYC) begin
         cyc();
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL ss_exit: got %h want %h", obs, exp_vec()); else n_pass++;
      end
   endtask

   task automatic test_reset_mid_step();
      int n;
      n = 0;
      while (STEP !== 3'd5 && n < 2 * BIT_CYC) begin cyc(); n++; end
      n_checks++;
      if (STEP !== 3'd5 || BOP !== 1'b1) $display("FAIL midreset_reach: got step %0d bop %b want 5 1", STEP, BOP); else n_pass++;
      repeat ($urandom_range(0, DIV - 2)) cyc();
      #2;
      RESETN = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (obs !== RESET_VEC) $display("FAIL midreset_outputs: got %h want %h", obs, RESET_VEC); else n_pass++;
      n_checks++;
      if (DBG_STATE !== 2'd0) $display("FAIL midreset_state: got %0d want 0", DBG_STATE); else n_pass++;
      PWR_OK = 1'b0;
      cyc();
      RESETN = 1'b1;
      cyc();
      n_checks++;
      if (obs !== RESET_VEC) $display("FAIL midreset_release: got %h want %h", obs, RESET_VEC); else n_pass++;
   endtask

   task automatic test_random_soak();
      do_reset();
      PWR_OK = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) PWR_OK = ~PWR_OK;
         if ($urandom_range(0, 149) == 0) SS_MODE = ~SS_MODE;
         if ($urandom_range(0, 2) == 0) SS_STEP = ~SS_STEP;
         cyc();
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL soak_cycle %0d: got %h want %h", c, obs, exp_vec()); else n_pass++;
         n_checks++;
         if (DBG_STATE !== 2'(m_state)) $display("FAIL soak_state %0d: got %0d want %0d", c, DBG_STATE, m_state); else n_pass++;
      end
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      RESETN = 1'b0; PWR_OK = 1'b0; SS_MODE = 1'b0; SS_STEP = 1'b0;
      model_reset();
      #1;
      test_reset();
      test_warmup();
      test_run_bt();
      test_drain();
      test_warmup_abort();
      test_single_step();
      test_reset_mid_step();
      test_random_soak();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/clock_phase_generator.md
# clock_phase_generator

Source of the three-phase timing references (CGPP/CGQP/CGRP and complements) and the BOP enable consumed by the clock drivers. It divides the master oscillator into an 8-step bit-time sequence and sequences power-up warm-up, BOP assertion and orderly shutdown. It also provides bit-time numbering for the rest of the computer. It sits between the oscillator/power-monitor logic and the clock drivers.

## Interface
- DIV, 4: CLK cycles per step; legal range ≥2.
- WARMUP, 2: full 8-step cycles run with BOP low before BOP asserts; legal range ≥1.
- BT_MAX, 13: last bit-time number; BT wraps BT_MAX→0.

- CLK  in  1  master oscillator clock; all state updates on rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- PWR_OK  in  1  power-good level, synchronous to CLK.
- SS_MODE  in  1  single-step maintenance mode.
- SS_STEP  in  1  single-step request level; its rising edge advances one step.
- CGPP, CGPPN  out  1 each  P phase reference and complement.
- CGQP, CGQPN  out  1 each  Q phase reference and complement.
- CGRP, CGRPN  out  1 each  R phase reference and complement.
- BOP  out  1  clock-driver enable.
- STEP  out  3  current step, 0..7.
- BT  out  4  current bit time, 0..BT_MAX.
- BT_END  out  1  one-CLK pulse on the final CLK of step 7; active in RUN/DRAIN only.
- RUNNING  out  1  high in WARMUP, RUN and DRAIN.

## Operation
- Phase map per step s:
  - P=1 for s∈{0,1,2,3}.
  - Q=1 for s∈{0,1,4,5}.
  - R=1 for s∈{1,2,5,6}.
  - Each *N output is the exact complement of its true output.
  - All six outputs are registered and change on the same edge as STEP.
- Divider DCNT counts 0..DIV-1. TICK is (DCNT==DIV-1) in free-run mode.
  - Each TICK advances STEP, 7→0 wrap.
- Single-step mode:
  - While SS_MODE=1, DCNT is held at 0.
  - A registered edge detector on SS_STEP generates TICK for exactly one CLK per rising edge.
  - Switching SS_MODE in either direction takes effect on the next CLK. STEP is kept; DCNT restarts from 0.
- State machine:
  - OFF: phases all 0, N outputs 1, BOP 0, STEP 0, DCNT 0. A CLK edge with PWR_OK=1 moves to WARMUP; at that edge STEP=0, DCNT=0 and the step-0 phase values load.
  - WARMUP: phases run, BOP 0. A counter counts TICKs with STEP=7.
    - On the TICK completing cycle number WARMUP, go to RUN, set BOP=1, set BT=0, STEP wraps to 0.
    - PWR_OK=0 in WARMUP returns to OFF at the next CLK edge.
  - RUN: BOP 1. On each TICK with STEP=7, BT increments, wrapping BT_MAX→0. PWR_OK=0 moves to DRAIN at the next edge.
  - DRAIN: BOP stays 1 and phases continue. On the TICK with STEP=7, go to OFF: BOP=0 and phases are forced to OFF values on that edge. PWR_OK returning high during DRAIN does not cancel the shutdown.
- BT_END = TICK & (STEP==7) & (RUN|DRAIN). It is combinational from registered state and a registered SS edge, so it is glitch-free.
- BT holds its value in OFF and WARMUP; it is cleared only on entry to RUN.
- Asynchronous reset:
  - Forces OFF; DCNT, STEP, BT and the warm-up count go to 0.
  - CGPP, CGQP, CGRP, BOP, BT_END and RUNNING go to 0; the N outputs go to 1.
  - Reset is permitted mid-step. The outputs change immediately with no partial step completion.

## Timing
- Free-run step length: DIV CLK cycles. Bit time: 8·DIV cycles.
- PWR_OK high (sampled at edge E) → BOP high at edge E + WARMUP·8·DIV. With the defaults that is 64 edges after E.
- PWR_OK low in RUN → BOP low on the edge completing the current step 7. Worst case is 8·DIV+1 edges.
- BT_END is high for exactly 1 CLK per bit time in free run. In SS mode it is high for the single CLK of the advancing edge.
- No output has combinational input-to-output paths except BT_END, which depends on SS_STEP only through its edge register.

## Test plan
- Reset release, PWR_OK=1, defaults → STEP 0..7 each held 4 CLKs; P/Q/R follow the phase map; N outputs always complementary; BOP rises exactly 64 edges after PWR_OK is sampled, coincident with STEP=0 and BT=0.
- RUN for 15 bit times → BT sequence 0..13,0; BT_END pulses once per 32 CLKs, on the last CLK of step 7.
- PWR_OK dropped at STEP=2 in RUN (re-raised 3 CLKs later) → BOP stays 1 through step 7, falls at the wrap edge with phases forced to 0/1; state OFF; re-entry then begins a fresh warm-up.
- PWR_OK dropped during WARMUP → OFF on the next edge; BOP never asserts; RUNNING falls.
- SS_MODE=1 in RUN with SS_STEP held high 5 CLKs, then toggled 8 times → exactly 1 step per rising edge; one BT_END pulse at the 7→0 step; no motion while SS_STEP is held high.
- RESETN asserted mid-step 5 in RUN → outputs go immediately to reset values (CGPP/CGQP/CGRP 0, N outputs 1, BOP 0, STEP 0, BT 0).
